// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if
// Bundles the IF/ID instruction, the redirect request and the registered
// ID/EX control word exchanged between the datapath and the control unit.
// master: the datapath/front-end side (drives the instruction and redirect).
// slave:  the control unit side (drives stall, flush and the ID/EX word).
interface ctrl_decode_pipe_if #(
  parameter int DST_W = 5
);
  logic [31:0]      id_inst_i;
  logic             redirect_i;
  logic             stall_o;
  logic             flush_o;
  logic [1:0]       ex_alu_op_o;
  logic             ex_reg_dest_o;
  logic             ex_branch_o;
  logic             ex_mem_read_o;
  logic             ex_mem_to_reg_o;
  logic             ex_mem_write_o;
  logic             ex_alu_src_o;
  logic             ex_reg_write_o;
  logic             ex_jump_o;
  logic [DST_W-1:0] ex_rs_o;
  logic [DST_W-1:0] ex_rt_o;
  logic [DST_W-1:0] ex_dst_o;
  logic [5:0]       ex_funct_o;
  logic             illegal_o;

  modport master (
    output id_inst_i,
    output redirect_i,
    input  stall_o,
    input  flush_o,
    input  ex_alu_op_o,
    input  ex_reg_dest_o,
    input  ex_branch_o,
    input  ex_mem_read_o,
    input  ex_mem_to_reg_o,
    input  ex_mem_write_o,
    input  ex_alu_src_o,
    input  ex_reg_write_o,
    input  ex_jump_o,
    input  ex_rs_o,
    input  ex_rt_o,
    input  ex_dst_o,
    input  ex_funct_o,
    input  illegal_o
  );

  modport slave (
    input  id_inst_i,
    input  redirect_i,
    output stall_o,
    output flush_o,
    output ex_alu_op_o,
    output ex_reg_dest_o,
    output ex_branch_o,
    output ex_mem_read_o,
    output ex_mem_to_reg_o,
    output ex_mem_write_o,
    output ex_alu_src_o,
    output ex_reg_write_o,
    output ex_jump_o,
    output ex_rs_o,
    output ex_rt_o,
    output ex_dst_o,
    output ex_funct_o,
    output illegal_o
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe
// Control unit for the 5-stage MIPS pipeline: decodes the IF/ID instruction,
// registers the control word into ID/EX, detects load-use hazards and
// sequences the bubbles that follow a branch/jump redirect.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (sticky illegal-opcode flag).
module ctrl_decode_pipe #(
  parameter int FLUSH_SLOTS = 2,
  parameter int DST_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  ctrl_decode_pipe_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int            CW       = $clog2(FLUSH_SLOTS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_SLOTS - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;

  logic [1:0]       r_alu_op;
  logic             r_reg_dest;
  logic             r_branch;
  logic             r_mem_read;
  logic             r_mem_to_reg;
  logic             r_mem_write;
  logic             r_alu_src;
  logic             r_reg_write;
  logic             r_jump;
  logic [DST_W-1:0] r_rs;
  logic [DST_W-1:0] r_rt;
  logic [DST_W-1:0] r_dst;
  logic [5:0]       r_funct;

  logic [5:0]       w_op;
  logic             w_inst_zero;
  logic [DST_W-1:0] w_rs;
  logic [DST_W-1:0] w_rt;
  logic [DST_W-1:0] w_rd;
  logic [DST_W-1:0] w_dst;
  logic [5:0]       w_funct;

  logic [1:0]       w_alu_op;
  logic             w_reg_dest;
  logic             w_branch;
  logic             w_mem_read;
  logic             w_mem_to_reg;
  logic             w_mem_write;
  logic             w_alu_src;
  logic             w_reg_write;
  logic             w_jump;

  logic             w_uses_rt;
  logic             w_hazard;
  logic             w_flush;
  logic             w_stall;
  logic             w_bubble;

  assign w_op        = bus.id_inst_i[31:26];
  assign w_inst_zero = (bus.id_inst_i == 32'h0000_0000);
  assign w_rs        = DST_W'(bus.id_inst_i[25:21]);
  assign w_rt        = DST_W'(bus.id_inst_i[20:16]);
  assign w_rd        = DST_W'(bus.id_inst_i[15:11]);
  assign w_funct     = bus.id_inst_i[5:0];

  // Opcode decode; every field starts at 0 so unknown opcodes and the
  // all-zero NOP fall out as bubbles.
  always_comb begin
    w_alu_op     = 2'b00;
    w_reg_dest   = 1'b0;
    w_branch     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_jump       = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        if (!w_inst_zero) begin
          w_alu_op     = 2'b10;
          w_reg_dest   = 1'b1;
          w_mem_to_reg = 1'b1;
          w_reg_write  = 1'b1;
        end
      end
      OP_LW: begin
        w_alu_op     = 2'b00;
        w_mem_read   = 1'b1;
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_SW: begin
        w_alu_op     = 2'b00;
        w_mem_write  = 1'b1;
        w_alu_src    = 1'b1;
      end
      OP_BEQ: begin
        w_alu_op     = 2'b01;
        w_branch     = 1'b1;
      end
      OP_ADDI: begin
        w_alu_op     = 2'b00;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_J: begin
        w_alu_op     = 2'b11;
        w_branch     = 1'b1;
        w_jump       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign w_dst = w_reg_dest ? w_rd : w_rt;

  // Only RType, sw and beq actually read rt; addi/lw write it instead.
  assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_SW) || (w_op == OP_BEQ);

  assign w_hazard = r_mem_read && (r_rt != '0) &&
                    ((r_rt == w_rs) || (w_uses_rt && (r_rt == w_rt)));

  // Redirect/FLUSH outranks the load-use stall; both read 0 while in reset.
  assign w_flush  = !rst && (bus.redirect_i || (r_state == FLUSH));
  assign w_stall  = w_hazard && !w_flush;
  assign w_bubble = w_flush || w_stall;

  assign bus.stall_o = w_stall;
  assign bus.flush_o = w_flush;

  // Flush sequencer: a redirect (re)loads the down-counter, and the machine
  // drops back to RUN after the cycle in which the counter reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.redirect_i) begin
            r_state <= FLUSH;
            r_cnt   <= CNT_LOAD;
          end
        end
        FLUSH: begin
          if (bus.redirect_i) begin
            r_cnt <= CNT_LOAD;
          end else if (r_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // ID/EX register: a stall or flush inserts an all-zero bubble, otherwise
  // the freshly decoded word moves into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_op     <= 2'b00;
      r_reg_dest   <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dst        <= '0;
      r_funct      <= 6'd0;
    end else if (w_bubble) begin
      r_alu_op     <= 2'b00;
      r_reg_dest   <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dst        <= '0;
      r_funct      <= 6'd0;
    end else begin
      r_alu_op     <= w_alu_op;
      r_reg_dest   <= w_reg_dest;
      r_branch     <= w_branch;
      r_mem_read   <= w_mem_read;
      r_mem_to_reg <= w_mem_to_reg;
      r_mem_write  <= w_mem_write;
      r_alu_src    <= w_alu_src;
      r_reg_write  <= w_reg_write;
      r_jump       <= w_jump;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_dst        <= w_dst;
      r_funct      <= w_funct;
    end
  end

  assign bus.ex_alu_op_o     = r_alu_op;
  assign bus.ex_reg_dest_o   = r_reg_dest;
  assign bus.ex_branch_o     = r_branch;
  assign bus.ex_mem_read_o   = r_mem_read;
  assign bus.ex_mem_to_reg_o = r_mem_to_reg;
  assign bus.ex_mem_write_o  = r_mem_write;
  assign bus.ex_alu_src_o    = r_alu_src;
  assign bus.ex_reg_write_o  = r_reg_write;
  assign bus.ex_jump_o       = r_jump;
  assign bus.ex_rs_o         = r_rs;
  assign bus.ex_rt_o         = r_rt;
  assign bus.ex_dst_o        = r_dst;
  assign bus.ex_funct_o      = r_funct;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic w_undecoded;
  logic r_illegal;

  assign w_undecoded = !((w_op == OP_RTYPE) || (w_op == OP_LW) ||
                         (w_op == OP_SW)    || (w_op == OP_BEQ) ||
                         (w_op == OP_ADDI)  || (w_op == OP_J));

  // Sticky trap flag: set only when an unknown opcode really advances into
  // EX (a stalled or squashed one never executes), cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (!w_bubble && w_undecoded) begin
      r_illegal <= 1'b1;
    end
  end

  assign bus.illegal_o = r_illegal;
`else
  assign bus.illegal_o = 1'b0;
`endif

endmodule
